// File: rtl/tcdm_varlat_bank_arb.sv
// tcdm_varlat_bank_arb: round-robin arbiter sharing one TCDM bank among NumIn masters; an in-order tag FIFO routes responses back.
// Latency: grant is combinational in the request cycle; a response is routed combinationally, at the earliest one cycle after its grant.
// Backpressure: req_o drops while MaxOutstanding requests are unanswered, and a low gnt_i stalls the winner. Define TCDM_VARLAT_ARB_STALL_CNT_EN to add a stall counter.

// Small generic FIFO used as the in-order tag store. Writes are ignored when full and reads are ignored when empty.
module tcdm_varlat_tag_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthCnt);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage: write the pushed tag at the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap explicitly so that depths other than powers of two work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

module tcdm_varlat_bank_arb #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned LogNumIn       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumIn-1:0]                   req_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0] data_i,
  output logic [NumIn-1:0]                   gnt_o,
  output logic [NumIn-1:0]                   vld_o,
  output logic [RespDataWidth-1:0]           rdata_o,
  output logic                               req_o,
  output logic [ReqDataWidth-1:0]            data_o,
  input  logic                               gnt_i,
  input  logic                               vld_i,
  input  logic [RespDataWidth-1:0]           rdata_i
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
  ,
  input  logic                               stall_clr_i,
  output logic [31:0]                        stall_cnt_o
`endif
);

  // One spare bit lets rr_q + offset exceed NumIn-1 before wrapping.
  localparam int unsigned IdxW = LogNumIn + 1;
  localparam logic [LogNumIn-1:0] LastIdx = LogNumIn'(NumIn - 1);
  localparam logic [IdxW-1:0]     NumIdx  = IdxW'(NumIn);

  logic [LogNumIn-1:0] rr_q;
  logic [LogNumIn-1:0] winner;
  logic [IdxW-1:0]     scan_idx;
  logic                found;
  logic                handshake;
  logic                fifo_empty;
  logic                fifo_full;
  logic [LogNumIn-1:0] head_tag;

  // Winner: first requester at or after rr_q, scanning cyclically.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      scan_idx = {1'b0, rr_q} + IdxW'(i);
      if (scan_idx >= NumIdx) begin
        scan_idx = scan_idx - NumIdx;
      end
      if (!found && req_i[scan_idx[LogNumIn-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[LogNumIn-1:0];
      end
    end
  end

  // The bank request depends only on requests and FIFO occupancy, never on gnt_i/vld_i.
  assign req_o     = (|req_i) & ~fifo_full;
  assign data_o    = data_i[winner];
  assign handshake = req_o & gnt_i;
  assign rdata_o   = rdata_i;

  // Grant goes only to the winner, and only when the bank accepts.
  always_comb begin
    gnt_o         = '0;
    gnt_o[winner] = handshake;
  end

  // Route the bank response to the master at the head of the tag FIFO; drop it if no request is outstanding.
  always_comb begin
    vld_o = '0;
    if (!fifo_empty) begin
      vld_o[head_tag] = vld_i;
    end
  end

  // Priority moves just past the last winner after each accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (handshake) begin
      rr_q <= (winner == LastIdx) ? '0 : winner + 1'b1;
    end
  end

  tcdm_varlat_tag_fifo #(
    .Width (LogNumIn),
    .Depth (MaxOutstanding)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .wdata_i (winner),
    .pop_i   (vld_i),
    .rdata_o (head_tag),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  // A stall is a cycle where some master requests but nothing is accepted.
  assign stall = (|req_i) & ~handshake;

  // Saturating stall counter; a clear wins over an increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (stall_clr_i) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the bank or the reset sequencing is broken.
  property p_no_orphan_resp;
    @(posedge clk_i) disable iff (!rst_ni) !(vld_i && fifo_empty);
  endproperty
  a_no_orphan_resp: assert property (p_no_orphan_resp)
    else $warning("tcdm_varlat_bank_arb: response with no outstanding request dropped");
`endif

endmodule

// File: tb/tb_tcdm_varlat_bank_arb.sv
// tb_tcdm_varlat_bank_arb: directed scenarios plus random traffic compared against a queue-based model.
// Latency: outputs are sampled 1 time unit after inputs change at the falling edge.
// Backpressure: the bank grant and response valid are driven by the bench.
`timescale 1ns/1ps
module tb_tcdm_varlat_bank_arb;
  localparam int N    = 4;
  localparam int RW   = 32;
  localparam int SW   = 32;
  localparam int MAXO = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N-1:0]         req_i = '0;
  logic [N-1:0][RW-1:0] data_i = '0;
  logic [N-1:0]         gnt_o;
  logic [N-1:0]         vld_o;
  logic [SW-1:0]        rdata_o;
  logic                 req_o;
  logic [RW-1:0]        data_o;
  logic                 gnt_i = 1'b0;
  logic                 vld_i = 1'b0;
  logic [SW-1:0]        rdata_i = '0;
  logic                 stall_clr_i = 1'b0;
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
  logic [31:0]          stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: a priority index, a queue of outstanding master IDs and a stall count.
  int      m_rr;
  int      m_q[$];
  longint  m_stall;
  logic    exp_req;
  logic [N-1:0]  exp_gnt;
  logic [N-1:0]  exp_vld;
  logic [RW-1:0] exp_data;
  int      exp_win;

  tcdm_varlat_bank_arb #(
    .NumIn(N), .ReqDataWidth(RW), .RespDataWidth(SW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
    .data_o(data_o), .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i)
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
    , .stall_clr_i(stall_clr_i), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_rr = 0;
    m_q.delete();
    m_stall = 0;
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic model_expect();
    exp_win = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(m_rr + i) % N]) exp_win = (m_rr + i) % N;
    end
    exp_req  = (req_i != '0) && (m_q.size() < MAXO);
    exp_data = data_i[exp_win];
    exp_gnt  = '0;
    if (exp_req && gnt_i) exp_gnt[exp_win] = 1'b1;
    exp_vld  = '0;
    if (vld_i && m_q.size() > 0) exp_vld[m_q[0]] = 1'b1;
  endtask

  // Clock-edge update of the model using the expectations of this cycle.
  task automatic model_advance();
    bit hs;
    hs = exp_req && gnt_i;
    if (stall_clr_i) m_stall = 0;
    else if (req_i != '0 && !hs && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (vld_i && m_q.size() > 0) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(exp_win);
      m_rr = (exp_win + 1) % N;
    end
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic cycle_end();
    model_advance();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic idle_inputs();
    req_i = '0; gnt_i = 1'b0; vld_i = 1'b0; stall_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    req_i = 4'b1111; gnt_i = 1'b1; vld_i = 1'b0;
    for (int i = 0; i < N; i++) data_i[i] = $urandom;
    do_reset();
    idle_inputs();
    rdata_i = '0;
    settle();
    total++; if (req_o !== 1'b0) begin bad++; $display("FAIL reset_req_o got=%b exp=0", req_o); end
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL reset_gnt_o got=%b exp=0000", gnt_o); end
    total++; if (vld_o !== 4'b0000) begin bad++; $display("FAIL reset_vld_o got=%b exp=0000", vld_o); end
    total++; if (rdata_o !== '0) begin bad++; $display("FAIL reset_rdata_o got=%h exp=0", rdata_o); end
    total++; if (data_o !== data_i[0]) begin bad++; $display("FAIL reset_data_o got=%h exp=%h", data_o, data_i[0]); end
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o); end
`endif
    cycle_end();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg, ev;
    for (int c = 0; c < 6; c++) begin
      req_i   = (c < 5) ? 4'b1111 : 4'b0000;
      gnt_i   = 1'b1;
      vld_i   = (c > 0);
      rdata_i = $urandom;
      settle();
      eg = (c < 5) ? (4'b0001 << (c % 4)) : 4'b0000;
      ev = (c > 0) ? (4'b0001 << ((c - 1) % 4)) : 4'b0000;
      total++; if (gnt_o !== eg) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt_o, eg); end
      total++; if (vld_o !== ev) begin bad++; $display("FAIL rr_vld c=%0d got=%b exp=%b", c, vld_o, ev); end
      total++; if (rdata_o !== rdata_i) begin bad++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, rdata_o, rdata_i); end
      cycle_end();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [3:0] rq [7];
    logic       vl [7];
    logic       er [7];
    logic [3:0] eg [7];
    logic [3:0] ev [7];
    rq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    vl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    eg = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0001};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_i = rq[c]; gnt_i = 1'b1; vld_i = vl[c];
      settle();
      total++; if (req_o !== er[c]) begin bad++; $display("FAIL full_req c=%0d got=%b exp=%b", c, req_o, er[c]); end
      total++; if (gnt_o !== eg[c]) begin bad++; $display("FAIL full_gnt c=%0d got=%b exp=%b", c, gnt_o, eg[c]); end
      total++; if (vld_o !== ev[c]) begin bad++; $display("FAIL full_vld c=%0d got=%b exp=%b", c, vld_o, ev[c]); end
      cycle_end();
    end
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
    total++; if (stall_cnt_o !== 32'd2) begin bad++; $display("FAIL full_stall got=%0d exp=2", stall_cnt_o); end
`endif
    idle_inputs();
  endtask

  task automatic test_varlat();
    logic [3:0]  rq [7];
    logic        vl [7];
    logic [31:0] rd [7];
    logic [3:0]  eg [7];
    logic [3:0]  ev [7];
    rq = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5, 32'h5A};
    eg = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    ev = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_i = rq[c]; gnt_i = 1'b1; vld_i = vl[c]; rdata_i = rd[c];
      settle();
      total++; if (gnt_o !== eg[c]) begin bad++; $display("FAIL vl_gnt c=%0d got=%b exp=%b", c, gnt_o, eg[c]); end
      total++; if (vld_o !== ev[c]) begin bad++; $display("FAIL vl_vld c=%0d got=%b exp=%b", c, vld_o, ev[c]); end
      if (vl[c]) begin
        total++; if (rdata_o !== rd[c]) begin bad++; $display("FAIL vl_rdata c=%0d got=%h exp=%h", c, rdata_o, rd[c]); end
      end
      cycle_end();
    end
    idle_inputs();
  endtask

  task automatic test_bank_stall();
    do_reset();
    for (int i = 0; i < N; i++) data_i[i] = $urandom;
    for (int c = 0; c < 3; c++) begin
      req_i = 4'b0100; gnt_i = 1'b0;
      settle();
      total++; if (req_o !== 1'b1) begin bad++; $display("FAIL stall_req c=%0d got=%b exp=1", c, req_o); end
      total++; if (data_o !== data_i[2]) begin bad++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, data_o, data_i[2]); end
      total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL stall_gnt c=%0d got=%b exp=0000", c, gnt_o); end
      cycle_end();
    end
    gnt_i = 1'b1;
    settle();
    total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL stall_release got=%b exp=0100", gnt_o); end
    cycle_end();
    // All masters request: the pointer must now sit at master 3.
    req_i = 4'b1111;
    settle();
    total++; if (gnt_o !== 4'b1000) begin bad++; $display("FAIL stall_rr got=%b exp=1000", gnt_o); end
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
    total++; if (stall_cnt_o !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt_o); end
`endif
    cycle_end();
    // FIFO now full: a stall cycle coinciding with a clear must leave zero.
    stall_clr_i = 1'b1;
    settle();
    total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL stall_full_gnt got=%b exp=0000", gnt_o); end
    cycle_end();
    req_i = '0; stall_clr_i = 1'b0; vld_i = 1'b1;
    settle();
    total++; if (vld_o !== 4'b0100) begin bad++; $display("FAIL stall_vld0 got=%b exp=0100", vld_o); end
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
    total++; if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL stall_clr got=%0d exp=0", stall_cnt_o); end
`endif
    cycle_end();
    settle();
    total++; if (vld_o !== 4'b1000) begin bad++; $display("FAIL stall_vld1 got=%b exp=1000", vld_o); end
    cycle_end();
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    req_i = '0; vld_i = 1'b1; gnt_i = 1'b1;
    settle();
    total++; if (vld_o !== 4'b0000) begin bad++; $display("FAIL spur_vld0 got=%b exp=0000", vld_o); end
    cycle_end();
    req_i = 4'b0001;
    settle();
    total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL spur_gnt got=%b exp=0001", gnt_o); end
    total++; if (vld_o !== 4'b0000) begin bad++; $display("FAIL spur_vld1 got=%b exp=0000", vld_o); end
    cycle_end();
    req_i = '0;
    settle();
    total++; if (vld_o !== 4'b0001) begin bad++; $display("FAIL spur_vld2 got=%b exp=0001", vld_o); end
    cycle_end();
    settle();
    total++; if (vld_o !== 4'b0000) begin bad++; $display("FAIL spur_vld3 got=%b exp=0000", vld_o); end
    cycle_end();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        idle_inputs();
        do_reset();
      end
      req_i = N'($urandom);
      for (int i = 0; i < N; i++) data_i[i] = $urandom;
      gnt_i = ($urandom_range(0, 3) != 0);
      vld_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      rdata_i = $urandom;
      stall_clr_i = ($urandom_range(0, 15) == 0);
      settle();
      total++; if (req_o !== exp_req) begin bad++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, req_o, exp_req); end
      total++; if (gnt_o !== exp_gnt) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt_o, exp_gnt); end
      total++; if (vld_o !== exp_vld) begin bad++; $display("FAIL rnd_vld c=%0d got=%b exp=%b", c, vld_o, exp_vld); end
      total++; if (data_o !== exp_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data_o, exp_data); end
      total++; if (rdata_o !== rdata_i) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata_o, rdata_i); end
`ifdef TCDM_VARLAT_ARB_STALL_CNT_EN
      total++; if (stall_cnt_o !== 32'(m_stall)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt_o, m_stall); end
`endif
      cycle_end();
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    test_reset();
    test_round_robin();
    test_full();
    test_varlat();
    test_bank_stall();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
